mem_wb_stage: RTL and testbench

- MEM pipe stage plus the MEM/WB pipeline register of the 5-stage, 48-instruction MIPS core.
- Issues data-memory requests for loads and stores through a req/ack handshake, stalling upstream while the request is in flight.
- Formats load data by sign- or zero-extension, then registers the instruction, ALU result, load data and link value into MEM_WB_* outputs.
- The write-back control decoder consumes MEM_WB_Instr; the WB mux consumes the data outputs.

---
 rtl/mem_wb_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory req/ack handshake, load extension and the MEM/WB register.
// Optional DMEM_TIMEOUT_EN adds an ack-wait counter that aborts a request and pulses dmem_timeout.
module mem_wb_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter bit          BIG_ENDIAN     = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] EX_MEM_Instr,
   input  logic [31:0] EX_MEM_ALUOut,
   input  logic [31:0] EX_MEM_WriteData,
   input  logic [31:0] EX_MEM_Link,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic [31:0] MEM_WB_Instr,
   output logic [31:0] MEM_WB_ALUOut,
   output logic [31:0] MEM_WB_MemData,
   output logic [31:0] MEM_WB_Link
`ifdef DMEM_TIMEOUT_EN
   ,
   output logic        dmem_timeout
`endif
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   state_e      state_q, state_d;
   logic [5:0]  op;
   logic        is_load, is_store, is_mem, is_unsigned, misalign;
   logic [1:0]  size, lane;
   logic        hsel;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, load_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        start_req, wb_take, timeout_hit;
   logic        unused_instr;

   assign op           = EX_MEM_Instr[31:26];
   assign unused_instr = ^EX_MEM_Instr[25:0];
   assign is_mem       = is_load | is_store;
   // XOR with all-ones is 3-addr for the byte lane; the halfword just flips addr[1]
   assign lane         = EX_MEM_ALUOut[1:0] ^ {2{BIG_ENDIAN}};
   assign hsel         = EX_MEM_ALUOut[1] ^ BIG_ENDIAN;

   always_comb begin
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_unsigned = 1'b0;
      size        = SzWord;
      case (op)
         6'd32:   begin is_load = 1'b1; size = SzByte; end
         6'd33:   begin is_load = 1'b1; size = SzHalf; end
         6'd35:   begin is_load = 1'b1; size = SzWord; end
         6'd36:   begin is_load = 1'b1; size = SzByte; is_unsigned = 1'b1; end
         6'd37:   begin is_load = 1'b1; size = SzHalf; is_unsigned = 1'b1; end
         6'd40:   begin is_store = 1'b1; size = SzByte; end
         6'd41:   begin is_store = 1'b1; size = SzHalf; end
         6'd43:   begin is_store = 1'b1; size = SzWord; end
         default: ;
      endcase
   end

   assign misalign = ((size == SzHalf) && EX_MEM_ALUOut[0]) ||
                     ((size == SzWord) && (EX_MEM_ALUOut[1:0] != 2'b00));

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = EX_MEM_WriteData;
      if (is_store) begin
         case (size)
            SzByte: begin
               be_d    = 4'b0001 << lane;
               wdata_d = {4{EX_MEM_WriteData[7:0]}};
            end
            SzHalf: begin
               be_d    = hsel ? 4'b1100 : 4'b0011;
               wdata_d = {2{EX_MEM_WriteData[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (lane)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = hsel ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (size)
         SzByte:  load_ext = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         SzHalf:  load_ext = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_ext = dmem_rdata;
      endcase
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CntW-1:0] cnt_q;

   assign timeout_hit  = (state_q == StWait) && !dmem_ack &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign dmem_timeout = timeout_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start_req) begin
         cnt_q <= '0;
      end else if ((state_q == StWait) && !dmem_ack) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      mem_stall    = 1'b0;
      mem_misalign = 1'b0;
      start_req    = 1'b0;
      wb_take      = 1'b0;
      case (state_q)
         StIdle: begin
            if (!is_mem) begin
               wb_take = 1'b1;
            end else if (misalign) begin
               mem_misalign = 1'b1;
            end else begin
               mem_stall = 1'b1;
               start_req = 1'b1;
               state_d   = StWait;
            end
         end
         default: begin
            if (dmem_ack) begin
               wb_take = 1'b1;
               state_d = StIdle;
            end else if (timeout_hit) begin
               state_d = StIdle;
            end else begin
               mem_stall = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
         MEM_WB_Instr   <= '0;
         MEM_WB_ALUOut  <= '0;
         MEM_WB_MemData <= '0;
         MEM_WB_Link    <= '0;
      end else begin
         state_q <= state_d;
         if (start_req) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {EX_MEM_ALUOut[31:2], 2'b00};
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
         end else if (state_d == StIdle) begin
            dmem_req <= 1'b0;
         end
         // Anything not completing this cycle becomes an all-zero bubble (sll $0)
         if (wb_take) begin
            MEM_WB_Instr   <= EX_MEM_Instr;
            MEM_WB_ALUOut  <= EX_MEM_ALUOut;
            MEM_WB_MemData <= is_load ? load_ext : 32'b0;
            MEM_WB_Link    <= EX_MEM_Link;
         end else begin
            MEM_WB_Instr   <= '0;
            MEM_WB_ALUOut  <= '0;
            MEM_WB_MemData <= '0;
            MEM_WB_Link    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a per-instruction behavioural model,
// plus directed literal checks for the key load/store/misalign/reset cases.
module tb_mem_wb_stage;

`ifdef DMEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] EX_MEM_Instr, EX_MEM_ALUOut, EX_MEM_WriteData, EX_MEM_Link;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack, mem_stall, mem_misalign;
   logic [31:0] MEM_WB_Instr, MEM_WB_ALUOut, MEM_WB_MemData, MEM_WB_Link;
`ifdef DMEM_TIMEOUT_EN
   logic        dmem_timeout;
`endif

   mem_wb_stage #(
      .TIMEOUT_CYCLES(TO),
      .BIG_ENDIAN    (1'b0)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .EX_MEM_Instr    (EX_MEM_Instr),
      .EX_MEM_ALUOut   (EX_MEM_ALUOut),
      .EX_MEM_WriteData(EX_MEM_WriteData),
      .EX_MEM_Link     (EX_MEM_Link),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_be         (dmem_be),
      .dmem_wdata      (dmem_wdata),
      .dmem_rdata      (dmem_rdata),
      .dmem_ack        (dmem_ack),
      .mem_stall       (mem_stall),
      .mem_misalign    (mem_misalign),
      .MEM_WB_Instr    (MEM_WB_Instr),
      .MEM_WB_ALUOut   (MEM_WB_ALUOut),
      .MEM_WB_MemData  (MEM_WB_MemData),
      .MEM_WB_Link     (MEM_WB_Link)
`ifdef DMEM_TIMEOUT_EN
      ,
      .dmem_timeout    (dmem_timeout)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // expectations for the current cycle
   logic        exp_stall, exp_mis, exp_req, exp_we, exp_to;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_be;
   logic        exp_wb_valid;
   logic [31:0] exp_wb_instr, exp_wb_alu, exp_wb_mem, exp_wb_link;
   // what MEM_WB must hold after the coming edge
   logic        pend_valid;
   logic [31:0] pend_instr, pend_alu, pend_mem, pend_link;

   // observation counters for directed checks (written only by the compare process)
   int          stall_seen = 0, mis_seen = 0, req_seen = 0, to_seen = 0;
   logic [31:0] last_addr = '0, last_wdata = '0;
   logic [3:0]  last_be = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
         check("mem_misalign", {31'b0, mem_misalign}, {31'b0, exp_mis});
         check("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
         check("wb_instr", MEM_WB_Instr, exp_wb_instr);
         if (exp_req) begin
            check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
            if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         if (exp_wb_valid) begin
            check("wb_aluout", MEM_WB_ALUOut, exp_wb_alu);
            check("wb_memdata", MEM_WB_MemData, exp_wb_mem);
            check("wb_link", MEM_WB_Link, exp_wb_link);
         end
`ifdef DMEM_TIMEOUT_EN
         check("dmem_timeout", {31'b0, dmem_timeout}, {31'b0, exp_to});
         if (dmem_timeout) to_seen++;
`endif
         if (mem_stall) stall_seen++;
         if (mem_misalign) mis_seen++;
         if (dmem_req) begin
            req_seen++;
            last_addr  = dmem_addr;
            last_be    = dmem_be;
            last_wdata = dmem_wdata;
         end
      end
   end

   function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                            input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * addr[1:0])) & 32'h0000_00FF;
      h = addr[1] ? (rd >> 16) : (rd & 32'h0000_FFFF);
      case (op)
         6'd32:   return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         6'd33:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         6'd36:   return b;
         6'd37:   return h;
         default: return rd;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
      exp_wb_valid = pend_valid;
      exp_wb_instr = pend_valid ? pend_instr : 32'b0;
      exp_wb_alu   = pend_alu;
      exp_wb_mem   = pend_mem;
      exp_wb_link  = pend_link;
   endtask

   task automatic set_bubble();
      pend_valid = 1'b0;
      pend_instr = '0;
      pend_alu   = '0;
      pend_mem   = '0;
      pend_link  = '0;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the instruction retires.
   task automatic run_instr(input logic [31:0] instr, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [31:0] link,
                            input logic [31:0] rdata, input int delay);
      logic [5:0] op;
      bit ld, st, mis, ack, to;
      op  = instr[31:26];
      ld  = op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37};
      st  = op inside {6'd40, 6'd41, 6'd43};
      mis = ((op == 6'd33 || op == 6'd37 || op == 6'd41) && alu[0]) ||
            ((op == 6'd35 || op == 6'd43) && alu[1:0] != 2'b00);
      EX_MEM_Instr = instr; EX_MEM_ALUOut = alu; EX_MEM_WriteData = wd; EX_MEM_Link = link;
      dmem_rdata = $urandom;
      dmem_ack   = 1'($urandom_range(0, 1));  // ack outside WAIT must be ignored
      exp_req = 1'b0; exp_to = 1'b0;
      exp_stall = (ld || st) && !mis;
      exp_mis   = (ld || st) && mis;
      if (!ld && !st) begin
         pend_valid = 1'b1; pend_instr = instr; pend_alu = alu; pend_mem = 0; pend_link = link;
      end else begin
         set_bubble();
      end
      if ((ld || st) && !mis) begin
         exp_we    = st;
         exp_addr  = alu & 32'hFFFF_FFFC;
         exp_wdata = (op == 6'd40) ? {4{wd[7:0]}} : (op == 6'd41) ? {2{wd[15:0]}} : wd;
         exp_be    = (op == 6'd40) ? (4'b0001 << alu[1:0]) :
                     (op == 6'd41) ? (alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
         for (int k = 0; k < 64; k++) begin
            next_cycle();
            ack = (k == delay);
`ifdef DMEM_TIMEOUT_EN
            to = !ack && (k == TO - 1);
`else
            to = 1'b0;
`endif
            dmem_ack   = ack;
            dmem_rdata = ack ? rdata : $urandom;
            exp_req    = 1'b1;
            exp_stall  = !ack && !to;
            exp_mis    = 1'b0;
            exp_to     = to;
            if (ack) begin
               pend_valid = 1'b1; pend_instr = instr; pend_alu = alu; pend_link = link;
               pend_mem   = ld ? ref_load(op, alu, rdata) : 32'b0;
            end else begin
               set_bubble();
            end
            if (ack || to) break;
         end
      end
      next_cycle();
   endtask

   localparam logic [31:0] AddI = 32'h0022_1820;  // add $3,$1,$2
   int s0, m0, r0, t0;

   initial begin
      logic [5:0] ops [10];
      logic [31:0] ins, a;
      ops = '{6'd0, 6'd8, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};
      rst_n = 1'b0;
      EX_MEM_Instr = '0; EX_MEM_ALUOut = '0; EX_MEM_WriteData = '0; EX_MEM_Link = '0;
      dmem_rdata = '0; dmem_ack = 1'b0;
      set_bubble();
      #12;
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_wb_instr", MEM_WB_Instr, 32'd0);
      check("rst_wb_alu", MEM_WB_ALUOut, 32'd0);
      check("rst_wb_mem", MEM_WB_MemData, 32'd0);
      check("rst_wb_link", MEM_WB_Link, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      chk_en = 1'b1;

      run_instr(AddI, 32'h5, 32'h0, 32'h44, 32'h0, 0);
      check("add_alu", MEM_WB_ALUOut, 32'h5);
      check("add_instr", MEM_WB_Instr, AddI);

      s0 = stall_seen;
      run_instr(32'h80A2_0000, 32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 0);
      check("lb_addr", last_addr, 32'h1000);
      check("lb_data", MEM_WB_MemData, 32'hFFFF_FF80);
      check("lb_stalls", stall_seen - s0, 32'd1);
      run_instr(32'h90A2_0000, 32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 0);
      check("lbu_data", MEM_WB_MemData, 32'h0000_0080);

      s0 = stall_seen;
      run_instr(32'hA4A2_0000, 32'h2002, 32'hABCD_5678, 32'h0, 32'h0, 3);
      check("sh_be", {28'b0, last_be}, 32'hC);
      check("sh_wdata", last_wdata, 32'h5678_5678);
      check("sh_stalls", stall_seen - s0, 32'd4);

      m0 = mis_seen; r0 = req_seen;
      run_instr(32'h8CA2_0000, 32'h3001, 32'h0, 32'h0, 32'h0, 0);
      check("lw_mis_pulses", mis_seen - m0, 32'd1);
      check("lw_mis_noreq", req_seen - r0, 32'd0);
      check("lw_mis_bubble", MEM_WB_Instr, 32'd0);

`ifdef DMEM_TIMEOUT_EN
      t0 = to_seen;
      run_instr(32'h8CA2_0000, 32'h3000, 32'h0, 32'h0, 32'h0, 100);
      check("timeout_pulses", to_seen - t0, 32'd1);
`endif

      // reset asserted mid-WAIT
      chk_en = 1'b0;
      EX_MEM_Instr = 32'h8CA2_0000; EX_MEM_ALUOut = 32'h4000; dmem_ack = 1'b0;
      @(posedge clk); #1;
      check("midwait_req", {31'b0, dmem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_req", {31'b0, dmem_req}, 32'd0);
      check("async_wb_instr", MEM_WB_Instr, 32'd0);
      check("async_wb_mem", MEM_WB_MemData, 32'd0);
      EX_MEM_Instr = AddI; EX_MEM_ALUOut = 32'h77; EX_MEM_Link = 32'h88;
      @(negedge clk);
      rst_n = 1'b1; dmem_ack = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req", {31'b0, dmem_req}, 32'd0);
      check("post_rst_stall", {31'b0, mem_stall}, 32'd0);
      check("post_rst_wb", MEM_WB_Instr, AddI);
      dmem_ack = 1'b0;
      exp_wb_valid = 1'b1; exp_wb_instr = AddI; exp_wb_alu = 32'h77;
      exp_wb_mem = 32'h0; exp_wb_link = 32'h88;
      chk_en = 1'b1;

      for (int i = 0; i < 300; i++) begin
         logic [5:0] op;
         op  = ops[$urandom_range(0, 9)];
         ins = $urandom;
         ins = (op == 6'd0) ? {6'd0, ins[25:6], 6'h20} : {op, ins[25:0]};
         a   = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         run_instr(ins, a, $urandom, $urandom, $urandom, $urandom_range(0, (TO > 4) ? 3 : TO - 2));
      end
      run_instr(AddI, 32'h1, 32'h0, 32'h0, 32'h0, 0);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
